an_cl37_arbiter: RTL and testbench
==================================

Name: an_cl37_arbiter

Overview:
Parametrised Clause 37 / SGMII auto-negotiation arbiter for the SGMII Ethernet path, the successor to the fixed-mode AN logic currently exercised in loopback. It sits between the 8b/10b ordered-set decoder/encoder and the MAC. It runs the Clause 37 state machine in either 1000BASE-X or SGMII mode (runtime-selectable), with per-mode link timers. It exports a 16-bit status word; bit 0 is AN complete.

Parameters:
LINK_TIMER_SGMII, 200000, link timer in clock cycles for SGMII mode (1.6 ms at 125 MHz).
LINK_TIMER_BASEX, 1250000, link timer in clock cycles for 1000BASE-X mode (10 ms at 125 MHz).
MATCH_COUNT, 3, consecutive identical words needed for ability, acknowledge and idle match.
TIMER_W, 21, timer counter width; must satisfy 2^TIMER_W > max(LINK_TIMER_*).

Ports:
clock  in  1  system clock, 125 MHz
reset  in  1  synchronous, active-high reset
mode_sgmii  in  1  1 = SGMII, 0 = 1000BASE-X; sampled only in AN_ENABLE
an_enable  in  1  0 forces AN_ENABLE
an_restart_config  in  1  rising edge restarts AN
local_ability  in  16  advertised config word (bit 14 ignored)
rx_sync  in  1  receiver code-group sync
rx_cfg_valid  in  1  one /C/ config word received this cycle
rx_cfg_word  in  16  received config word
rx_idle_valid  in  1  one /I/ received this cycle
tx_cfg_en  out  1  1 = encoder sends /C/, 0 = /I/
tx_cfg_word  out  16  word to transmit
an_complete  out  1  AN in LINK_OK
partner_ability  out  16  latched partner word
speed  out  2  00 = 10M, 01 = 100M, 10 = 1000M
duplex  out  1  1 = full
eth_status  out  16  status word

Behaviour:
- Reset values: state AN_ENABLE, tx_cfg_en=1, tx_cfg_word=0, an_complete=0, partner_ability=0, speed=2'b10, duplex=0, eth_status=0, timer=0, all match counters 0.
- Restart edge register resets to 1, so a level held high out of reset is not a restart.
- Ability match: MATCH_COUNT consecutive rx_cfg_valid words equal with bit 14 masked. A differing word reloads the count to 1. rx_idle_valid clears the count.
- Acknowledge match: the same rule, with bit 14=1 additionally required.
- Idle match: MATCH_COUNT consecutive rx_idle_valid. Any rx_cfg_valid clears the count.
- Consistency: acknowledged word [13:0] and [15] equal the latched partner_ability.
- Timer: loads 0 on every state entry and increments each cycle. timer_done is asserted when timer equals the mode limit minus 1, and the timer then holds. Outputs are registered, giving 1-cycle latency from state to outputs.
- Global priority, evaluated every cycle: reset > !an_enable or !rx_sync (go to AN_ENABLE) > restart edge (go to AN_RESTART) > per-state transition.
- States (3-bit code in brackets):
  - AN_ENABLE[0]: tx /C/ with word 0; latches mode. If an_enable & rx_sync, go to AN_RESTART.
  - AN_RESTART[1]: tx word 0. On timer_done, go to ABILITY_DETECT.
  - ABILITY_DETECT[2]: tx local_ability with bit14=0. On ability match with a non-zero word, latch partner_ability and go to ACK_DETECT.
  - ACK_DETECT[3]: tx bit14=1.
    - Acknowledge match & consistent: go to COMPLETE_ACK.
    - Acknowledge match & inconsistent: go to AN_ENABLE.
    - Ability match on word 0: go to AN_ENABLE.
  - COMPLETE_ACK[4]: tx bit14=1. Timer_done & no zero-word match: go to IDLE_DETECT.
  - IDLE_DETECT[5]: tx_cfg_en=0. Timer_done & idle match: go to LINK_OK. Ability match on any word: go to AN_ENABLE.
  - LINK_OK[6]: an_complete=1. Ability match (partner restart): go to AN_ENABLE.
- Speed and duplex decode, updated on entry to LINK_OK:
  - SGMII: speed=partner[11:10] (11 maps to 10), duplex=partner[12].
  - BASE-X: speed=10, duplex=partner[5].
- SGMII mode: tx_cfg_word is 16'h4001 in ACK states and 16'h0001 in ABILITY_DETECT; local_ability is ignored.
- eth_status fields:
  - [0] an_complete
  - [1] rx_sync
  - [2] link: SGMII uses partner[15]; BASE-X uses an_complete
  - [4:3] speed
  - [5] duplex
  - [6] mode latched
  - [7] 0
  - [10:8] state
  - [15:11] see Optional Feature
- Simultaneous restart edge and LINK_OK exit: restart wins.

Optional Feature:
AN_RESTART_COUNT_EN
- Defined: 5-bit saturating counter (stops at 31) of LINK_OK exits plus restart edges, cleared only by reset, driven on eth_status[15:11].
- Undefined: eth_status[15:11]=0, no counter logic.

Decomposition:
- Package an_cl37_pkg: state enum (3-bit), ACK_BIT=14, SGMII_TX_ABILITY=16'h0001, eth_status bit-position constants, speed encodings.
- Sub-module an_match_counter (parameters MATCH_COUNT, W): tracks the last word, mask, and count, and outputs match and match_word. Instantiated twice (config, idle).

Test Plan:
- Loopback tx_cfg_word/tx_cfg_en to rx in BASE-X, LINK_TIMER_BASEX=64, local_ability=16'h0020:
  - eth_status[0]=1 within 400 cycles.
  - partner_ability=16'h0020, duplex=1, speed=10, status state=6.
- SGMII, timers=64, PHY model replies 16'hD801 (link, FD, 1000M, ack):
  - LINK_OK reached.
  - speed=10, duplex=1, eth_status[2]=1.
- In LINK_OK, drive rx_sync=0 for 1 cycle:
  - Next cycle state=0, an_complete=0.
  - Re-negotiates to LINK_OK.
- an_restart_config held 1 from reset:
  - No restart occurs.
  - A 0->1 pulse in LINK_OK moves to AN_RESTART (state=1) next cycle.
  - With AN_RESTART_COUNT_EN, eth_status[15:11]=1.
- In ACK_DETECT, inject 3 acked words differing in bit 5 from the latched word:
  - Go to AN_ENABLE.
  - 2 matching words followed by 1 differing word must not match.
- Assert reset mid-COMPLETE_ACK:
  - All outputs return to reset values on the next cycle.
  - Timer restarts from 0.

Source files
------------

// File: rtl/an_cl37_pkg.sv
// Shared types and constants for the Clause 37 / SGMII auto-negotiation arbiter.
package an_cl37_pkg;

    typedef enum logic [2:0] {
        AN_ENABLE      = 3'd0,
        AN_RESTART     = 3'd1,
        ABILITY_DETECT = 3'd2,
        ACK_DETECT     = 3'd3,
        COMPLETE_ACK   = 3'd4,
        IDLE_DETECT    = 3'd5,
        LINK_OK        = 3'd6
    } an_state_e;

    localparam int          ACK_BIT          = 14;
    localparam logic [15:0] ACK_MASK         = 16'h1 << ACK_BIT;
    localparam logic [15:0] CFG_MASK         = ~ACK_MASK;
    localparam logic [15:0] SGMII_TX_ABILITY = 16'h0001;

    localparam int ST_AN_COMPLETE = 0;
    localparam int ST_RX_SYNC     = 1;
    localparam int ST_LINK        = 2;
    localparam int ST_SPEED_LO    = 3;
    localparam int ST_DUPLEX      = 5;
    localparam int ST_MODE        = 6;
    localparam int ST_STATE_LO    = 8;
    localparam int ST_RCNT_LO     = 11;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

endpackage

// File: rtl/an_match_counter.sv
// Consecutive-identical-word detector; a differing word reloads the run to 1.
module an_match_counter #(
    parameter int MATCH_COUNT = 3,
    parameter int W           = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid,
    input  logic [W-1:0] word,
    input  logic [W-1:0] mask,
    input  logic         clear,
    output logic         match,
    output logic [W-1:0] match_word
);
    localparam int CW = $clog2(MATCH_COUNT + 1);

    logic [CW-1:0] count;
    logic [W-1:0]  last_word;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (valid) begin
            if (count != '0 && ((word ^ last_word) & mask) == '0) begin
                if (count != CW'(MATCH_COUNT)) count <= count + 1'b1;
            end else begin
                count <= CW'(1);
            end
        end
    end

    // The word register is pure data and needs no reset: it is only observed behind match.
    always_ff @(posedge clock) begin
        if (valid) last_word <= word;
    end

    assign match      = (count == CW'(MATCH_COUNT));
    assign match_word = last_word & mask;

endmodule

// File: rtl/an_cl37_arbiter.sv
// Clause 37 / SGMII auto-negotiation arbiter with per-mode link timers.
// Define AN_RESTART_COUNT_EN to expose a saturating restart counter on eth_status[15:11].
module an_cl37_arbiter
    import an_cl37_pkg::*;
#(
    parameter int LINK_TIMER_SGMII = 200000,
    parameter int LINK_TIMER_BASEX = 1250000,
    parameter int MATCH_COUNT      = 3,
    parameter int TIMER_W          = 21
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mode_sgmii,
    input  logic        an_enable,
    input  logic        an_restart_config,
    input  logic [15:0] local_ability,
    input  logic        rx_sync,
    input  logic        rx_cfg_valid,
    input  logic [15:0] rx_cfg_word,
    input  logic        rx_idle_valid,
    output logic        tx_cfg_en,
    output logic [15:0] tx_cfg_word,
    output logic        an_complete,
    output logic [15:0] partner_ability,
    output logic [1:0]  speed,
    output logic        duplex,
    output logic [15:0] eth_status
);
    localparam int CW = $clog2(MATCH_COUNT + 1);

    an_state_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_last;
    logic               timer_done, state_entry, take_restart;
    logic               restart_q, restart_edge, mode_q;
    logic               cfg_match, idle_match, ack_match, consistent, zero_word;
    logic [15:0]        cfg_word;
    logic [0:0]         idle_word_unused;
    logic [CW-1:0]      ack_run;
    logic [1:0]         speed_d;
    logic               duplex_d, tx_en_d;
    logic [15:0]        tx_word_d, status_d;
    logic [4:0]         rcnt_field;

    assign restart_edge = an_restart_config & ~restart_q;
    assign timer_last   = mode_q ? TIMER_W'(LINK_TIMER_SGMII - 1) : TIMER_W'(LINK_TIMER_BASEX - 1);
    assign timer_done   = (timer_q == timer_last);

    an_match_counter #(.MATCH_COUNT(MATCH_COUNT), .W(16)) u_cfg_match (
        .clock      (clock),
        .reset      (reset),
        .valid      (rx_cfg_valid),
        .word       (rx_cfg_word),
        .mask       (CFG_MASK),
        .clear      (rx_idle_valid | state_entry),
        .match      (cfg_match),
        .match_word (cfg_word)
    );

    an_match_counter #(.MATCH_COUNT(MATCH_COUNT), .W(1)) u_idle_match (
        .clock      (clock),
        .reset      (reset),
        .valid      (rx_idle_valid),
        .word       (1'b0),
        .mask       (1'b1),
        .clear      (rx_cfg_valid | state_entry),
        .match      (idle_match),
        .match_word (idle_word_unused)
    );

    // Run of consecutive words carrying the ack bit; together with cfg_match this is acknowledge match.
    always_ff @(posedge clock) begin
        if (reset || rx_idle_valid || state_entry) begin
            ack_run <= '0;
        end else if (rx_cfg_valid) begin
            if (!rx_cfg_word[ACK_BIT])             ack_run <= '0;
            else if (ack_run != CW'(MATCH_COUNT)) ack_run <= ack_run + 1'b1;
        end
    end

    assign ack_match  = cfg_match && (ack_run == CW'(MATCH_COUNT));
    assign consistent = (cfg_word == partner_ability);
    assign zero_word  = (cfg_word == '0);

    always_comb begin
        state_d      = state_q;
        take_restart = 1'b0;
        if (!an_enable || !rx_sync) begin
            state_d = AN_ENABLE;
        end else if (restart_edge) begin
            state_d      = AN_RESTART;
            take_restart = 1'b1;
        end else begin
            case (state_q)
                AN_ENABLE:      state_d = AN_RESTART;
                AN_RESTART:     if (timer_done) state_d = ABILITY_DETECT;
                ABILITY_DETECT: if (cfg_match && !zero_word) state_d = ACK_DETECT;
                ACK_DETECT: begin
                    if (ack_match)                   state_d = consistent ? COMPLETE_ACK : AN_ENABLE;
                    else if (cfg_match && zero_word) state_d = AN_ENABLE;
                end
                COMPLETE_ACK:   if (timer_done && !(cfg_match && zero_word)) state_d = IDLE_DETECT;
                IDLE_DETECT: begin
                    if (timer_done && idle_match) state_d = LINK_OK;
                    else if (cfg_match)           state_d = AN_ENABLE;
                end
                LINK_OK:        if (cfg_match) state_d = AN_ENABLE;
                default:        state_d = AN_ENABLE;
            endcase
        end
        state_entry = (state_d != state_q) || take_restart;
    end

    always_comb begin
        speed_d  = SPEED_1000;
        duplex_d = partner_ability[5];
        if (mode_q) begin
            case (partner_ability[11:10])
                2'b00:   speed_d = SPEED_10;
                2'b01:   speed_d = SPEED_100;
                default: speed_d = SPEED_1000;
            endcase
            duplex_d = partner_ability[12];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= AN_ENABLE;
            timer_q         <= '0;
            restart_q       <= 1'b1;
            mode_q          <= 1'b0;
            partner_ability <= '0;
            speed           <= SPEED_1000;
            duplex          <= 1'b0;
        end else begin
            state_q   <= state_d;
            restart_q <= an_restart_config;
            if (state_entry)     timer_q <= '0;
            else if (!timer_done) timer_q <= timer_q + 1'b1;
            if (state_q == AN_ENABLE) mode_q <= mode_sgmii;
            if (state_q == ABILITY_DETECT && state_d == ACK_DETECT) partner_ability <= cfg_word;
            if (state_d == LINK_OK && state_q != LINK_OK) begin
                speed  <= speed_d;
                duplex <= duplex_d;
            end
        end
    end

`ifdef AN_RESTART_COUNT_EN
    logic [4:0] restart_cnt;
    logic       link_exit;

    assign link_exit = (state_q == LINK_OK) && (state_d != LINK_OK);

    always_ff @(posedge clock) begin
        if (reset)                                               restart_cnt <= '0;
        else if ((restart_edge || link_exit) && restart_cnt != 5'd31) restart_cnt <= restart_cnt + 1'b1;
    end

    assign rcnt_field = restart_cnt;
`else
    assign rcnt_field = '0;
`endif

    always_comb begin
        tx_en_d   = 1'b1;
        tx_word_d = '0;
        case (state_q)
            ABILITY_DETECT:           tx_word_d = mode_q ? SGMII_TX_ABILITY : (local_ability & CFG_MASK);
            ACK_DETECT, COMPLETE_ACK: tx_word_d = mode_q ? (SGMII_TX_ABILITY | ACK_MASK) : (local_ability | ACK_MASK);
            IDLE_DETECT, LINK_OK:     tx_en_d   = 1'b0;
            default:                  ;
        endcase

        status_d                      = '0;
        status_d[ST_AN_COMPLETE]      = (state_q == LINK_OK);
        status_d[ST_RX_SYNC]          = rx_sync;
        status_d[ST_LINK]             = mode_q ? partner_ability[15] : (state_q == LINK_OK);
        status_d[ST_SPEED_LO +: 2]    = speed;
        status_d[ST_DUPLEX]           = duplex;
        status_d[ST_MODE]             = mode_q;
        status_d[ST_STATE_LO +: 3]    = state_q;
        status_d[ST_RCNT_LO +: 5]     = rcnt_field;
    end

    // Output register stage: everything below lags state_q by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_cfg_en   <= 1'b1;
            tx_cfg_word <= '0;
            an_complete <= 1'b0;
            eth_status  <= '0;
        end else begin
            tx_cfg_en   <= tx_en_d;
            tx_cfg_word <= tx_word_d;
            an_complete <= (state_q == LINK_OK);
            eth_status  <= status_d;
        end
    end

endmodule

// File: tb/tb_an_cl37_arbiter.sv
// Directed bench for an_cl37_arbiter: loopback, PHY-reply table and hand-built corner sequences.
module tb_an_cl37_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        mode_sgmii, an_enable, an_restart_config, rx_sync;
    logic [15:0] local_ability;
    logic        rx_cfg_valid, rx_idle_valid;
    logic [15:0] rx_cfg_word;
    logic        tx_cfg_en, an_complete, duplex;
    logic [15:0] tx_cfg_word, partner_ability, eth_status;
    logic [1:0]  speed;

    logic [1:0]  src;
    logic [15:0] phy_word;
    logic        man_cfg_valid, man_idle_valid;
    logic [15:0] man_cfg_word;

    int checks = 0;
    int errors = 0;

`ifdef AN_RESTART_COUNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    typedef struct packed {
        logic        sgmii;
        logic [15:0] reply;
        logic [15:0] partner;
        logic [1:0]  spd;
        logic        dup;
        logic        link;
        logic [15:0] ack_tx;
    } vec_t;

    vec_t vecs [6];

    always #5 clock = ~clock;

    // src: 0 = manual words, 1 = loopback of our own tx, 2 = PHY that answers /C/ with phy_word.
    always_comb begin
        case (src)
            2'd1: begin
                rx_cfg_valid  = tx_cfg_en;
                rx_cfg_word   = tx_cfg_word;
                rx_idle_valid = !tx_cfg_en;
            end
            2'd2: begin
                rx_cfg_valid  = tx_cfg_en;
                rx_cfg_word   = phy_word;
                rx_idle_valid = !tx_cfg_en;
            end
            default: begin
                rx_cfg_valid  = man_cfg_valid;
                rx_cfg_word   = man_cfg_word;
                rx_idle_valid = man_idle_valid;
            end
        endcase
    end

    an_cl37_arbiter #(
        .LINK_TIMER_SGMII (64),
        .LINK_TIMER_BASEX (64),
        .MATCH_COUNT      (3),
        .TIMER_W          (21)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .mode_sgmii        (mode_sgmii),
        .an_enable         (an_enable),
        .an_restart_config (an_restart_config),
        .local_ability     (local_ability),
        .rx_sync           (rx_sync),
        .rx_cfg_valid      (rx_cfg_valid),
        .rx_cfg_word       (rx_cfg_word),
        .rx_idle_valid     (rx_idle_valid),
        .tx_cfg_en         (tx_cfg_en),
        .tx_cfg_word       (tx_cfg_word),
        .an_complete       (an_complete),
        .partner_ability   (partner_ability),
        .speed             (speed),
        .duplex            (duplex),
        .eth_status        (eth_status)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_tx_en"},   16'(tx_cfg_en),       16'h0001);
        check({name, "_tx_word"}, tx_cfg_word,          16'h0000);
        check({name, "_an"},      16'(an_complete),     16'h0000);
        check({name, "_partner"}, partner_ability,      16'h0000);
        check({name, "_speed"},   16'(speed),           16'h0002);
        check({name, "_duplex"},  16'(duplex),          16'h0000);
        check({name, "_status"},  eth_status,           16'h0000);
    endtask

    task automatic wait_state(input logic [2:0] st, input int max, input string name);
        int n = 0;
        while (eth_status[10:8] !== st && n < max) begin
            tick();
            n++;
        end
        check(name, 16'(eth_status[10:8]), 16'(st));
    endtask

    task automatic wait_an(input int max, input string name);
        int n = 0;
        while (eth_status[0] !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check(name, 16'(eth_status[0]), 16'h0001);
    endtask

    task automatic send_cfg(input logic [15:0] w);
        man_cfg_valid = 1'b1;
        man_cfg_word  = w;
        tick();
        man_cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [15:0] exp_status;

        vecs[0] = '{1'b1, 16'hD801, 16'h9801, 2'b10, 1'b1, 1'b1, 16'h4001};
        vecs[1] = '{1'b1, 16'hC401, 16'h8401, 2'b01, 1'b0, 1'b1, 16'h4001};
        vecs[2] = '{1'b1, 16'h5C01, 16'h1C01, 2'b10, 1'b1, 1'b0, 16'h4001};
        vecs[3] = '{1'b1, 16'h4001, 16'h0001, 2'b00, 1'b0, 1'b0, 16'h4001};
        vecs[4] = '{1'b0, 16'h41A0, 16'h01A0, 2'b10, 1'b1, 1'b1, 16'h4020};
        vecs[5] = '{1'b0, 16'h4040, 16'h0040, 2'b10, 1'b0, 1'b1, 16'h4020};

        reset = 1'b1; an_enable = 1'b1; rx_sync = 1'b1; an_restart_config = 1'b1;
        mode_sgmii = 1'b0; local_ability = 16'h0020; src = 2'd1; phy_word = '0;
        man_cfg_valid = 1'b0; man_idle_valid = 1'b0; man_cfg_word = '0;
        tick();
        tick();
        check_reset("rst0");
        reset = 1'b0;

        // BASE-X loopback with restart level held high since reset
        wait_an(400, "lb_done");
        check("lb_partner", partner_ability, 16'h0020);
        check("lb_duplex", 16'(duplex), 16'h0001);
        check("lb_speed", 16'(speed), 16'h0002);
        check("lb_state", 16'(eth_status[10:8]), 16'h0006);
        check("lb_link", 16'(eth_status[2]), 16'h0001);

        // Restart pulse in LINK_OK
        an_restart_config = 1'b0;
        tick();
        an_restart_config = 1'b1;
        tick();
        tick();
        check("rs_state", 16'(eth_status[10:8]), 16'h0001);
        check("rs_an", 16'(an_complete), 16'h0000);
        check("rs_cnt", 16'(eth_status[15:11]), 16'(CNT_ON));
        wait_an(400, "rs_reneg");

        // One-cycle loss of sync in LINK_OK
        rx_sync = 1'b0;
        tick();
        rx_sync = 1'b1;
        tick();
        check("sync_state", 16'(eth_status[10:8]), 16'h0000);
        check("sync_an", 16'(an_complete), 16'h0000);
        check("sync_cnt", 16'(eth_status[15:11]), 16'(2 * CNT_ON));
        wait_an(400, "sync_reneg");

        // Manual words: latch 0x0021, then broken runs and an inconsistent ack
        src = 2'd0; an_restart_config = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_state(3'd2, 200, "man_abil");
        for (int i = 0; i < 3; i++) send_cfg(16'h0021);
        tick();
        tick();
        check("man_ack_state", 16'(eth_status[10:8]), 16'h0003);
        check("man_partner", partner_ability, 16'h0021);
        send_cfg(16'h4021);
        send_cfg(16'h4021);
        send_cfg(16'h4001);
        tick();
        tick();
        tick();
        check("man_nomatch", 16'(eth_status[10:8]), 16'h0003);
        send_cfg(16'h4001);
        send_cfg(16'h4001);
        tick();
        tick();
        check("man_inconsistent", 16'(eth_status[10:8]), 16'h0000);

        // Reset in COMPLETE_ACK, then time AN_RESTART from scratch
        src = 2'd1; reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_state(3'd4, 300, "cack_reach");
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_reset("cack_rst");
        reset = 1'b0;
        n = 0;
        while (eth_status[10:8] !== 3'd2 && n < 200) begin
            tick();
            n++;
        end
        check("cack_timer", 16'(n), 16'd66);

        // PHY-reply table
        for (int v = 0; v < 6; v++) begin
            src = 2'd2; phy_word = vecs[v].reply; mode_sgmii = vecs[v].sgmii;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            wait_state(3'd3, 300, $sformatf("v%0d_ack", v));
            check($sformatf("v%0d_ack_tx", v), tx_cfg_word, vecs[v].ack_tx);
            wait_an(400, $sformatf("v%0d_done", v));
            exp_status = {5'd0, 3'd6, 1'b0, vecs[v].sgmii, vecs[v].dup, vecs[v].spd, vecs[v].link, 2'b11};
            check($sformatf("v%0d_partner", v), partner_ability, vecs[v].partner);
            check($sformatf("v%0d_speed", v), 16'(speed), 16'(vecs[v].spd));
            check($sformatf("v%0d_duplex", v), 16'(duplex), 16'(vecs[v].dup));
            check($sformatf("v%0d_status", v), eth_status, exp_status);
            check($sformatf("v%0d_tx_en", v), 16'(tx_cfg_en), 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
